// File: rtl/exp_pkg.sv
// Shared definitions for the exponential accelerator front end.
// Also used by the accelerator core and its bench.
package exp_pkg;

  localparam int X_W    = 16;
  localparam int INT_W  = 2;
  localparam int FRAC_W = 16;
  localparam int RES_W  = INT_W + FRAC_W;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    HOLD
  } state_e;

  function automatic logic [RES_W-1:0] pack_res(
    input logic [INT_W-1:0]  ip,
    input logic [FRAC_W-1:0] fp
  );
    return {ip, fp};
  endfunction

endpackage

// File: rtl/exp_fifo.sv
// Synchronous operand FIFO with full/empty/count.
// Read data is the head entry; no write-to-read bypass.
module exp_fifo
  import exp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = X_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/exp_dispatcher.sv
// Queues operands and runs the exp accelerator one job at a time,
// returning {intpart, fracpart} or a timeout error per job.
module exp_dispatcher
  import exp_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    in_x,
  output logic              exp_start,
  output logic [X_W-1:0]    exp_x,
  input  logic              exp_done,
  input  logic [INT_W-1:0]  exp_intpart,
  input  logic [FRAC_W-1:0] exp_fracpart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic              out_err,
  output logic              busy
);

  localparam int CW  = $clog2(DEPTH);
  localparam int TW0 = $clog2(TIMEOUT + 1);
  localparam int TW  = (TW0 < 10) ? 10 : TW0;
  localparam int SW  = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  state_e         state;
  logic [SW-1:0]  scnt;
  logic [TW-1:0]  wcnt;
  logic [TW:0]    wnext;
  logic           done_q;
  logic           done_edge;
  logic           timeout_hit;
  logic           last_start;
  logic           full;
  logic           empty;
  logic [CW:0]    count;
  logic [X_W-1:0] head;
  logic           push;
  logic           pop;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty;

  exp_fifo #(
    .DEPTH (DEPTH),
    .W     (X_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_x),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A level left high from an earlier job must not complete this one.
  assign done_edge   = exp_done && !done_q;
  assign wnext       = {1'b0, wcnt} + 1'b1;
  assign timeout_hit = wnext == (TW+1)'(TIMEOUT);
  assign last_start  = scnt == SW'(START_LEN - 1);
  assign exp_start   = state == START;
  assign busy        = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= exp_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scnt       <= '0;
      wcnt       <= '0;
      exp_x      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            exp_x <= head;
            scnt  <= '0;
            wcnt  <= '0;
            state <= START;
          end
        end
        START: begin
          if (last_start) state <= WAIT;
          else            scnt  <= scnt + 1'b1;
        end
        WAIT: begin
          if (wcnt != '1) wcnt <= wcnt + 1'b1;
          // Completion takes priority over a coincident timeout.
          if (done_edge) begin
            out_result <= pack_res(exp_intpart, exp_fracpart);
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else if (timeout_hit) begin
            out_result <= '0;
            out_err    <= 1'b1;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_dispatcher.sv
// Bench for exp_dispatcher: timestamp-based reference model,
// per-cycle compare, and directed scenarios with literal checks.
module tb_exp_dispatcher;

  localparam int DEPTH     = 4;
  localparam int START_LEN = 2;
  localparam int TIMEOUT   = 1023;
  localparam int M_PULSE   = 0;
  localparam int M_STICKY  = 1;
  localparam int M_NEVER   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        exp_start;
  logic [15:0] exp_x;
  logic        exp_done;
  logic [1:0]  exp_intpart;
  logic [15:0] exp_fracpart;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_result;
  logic        out_err;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  exp_dispatcher #(
    .DEPTH     (DEPTH),
    .START_LEN (START_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .exp_start    (exp_start),
    .exp_x        (exp_x),
    .exp_done     (exp_done),
    .exp_intpart  (exp_intpart),
    .exp_fracpart (exp_fracpart),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_err      (out_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] acc_f(input logic [15:0] x);
    if (x == 16'd3080) return {2'd1, 16'd3160};
    return {x[15:14], ~x};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Accelerator model
  int          acc_mode = M_PULSE;
  int          acc_lat  = 20;
  int          cd  = 0;
  int          dcd = 0;
  bit          sp  = 0;
  bit          acc_r;
  logic [17:0] acc_res = '0;

  assign exp_intpart  = acc_res[17:16];
  assign exp_fracpart = acc_res[15:0];

  initial exp_done = 1'b0;

  always @(posedge clk) begin
    acc_r = rst;
    #1;
    if (acc_r) begin
      cd = 0; dcd = 0; sp = 0; exp_done = 1'b0;
    end else begin
      if (acc_mode != M_STICKY) exp_done = 1'b0;
      if (dcd > 0) begin
        dcd--;
        if (dcd == 0) exp_done = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0 && acc_mode != M_NEVER) exp_done = 1'b1;
      end
      if (exp_start && !sp) begin
        cd = acc_lat;
        acc_res = acc_f(exp_x);
        if (acc_mode == M_STICKY) dcd = 10;
      end
      sp = exp_start;
    end
  end

  // Reference model: operand queue plus job timestamps
  logic [15:0] mq[$];
  int          m_cyc  = 0;
  bit          m_live = 0;
  bit          m_job  = 0;
  bit          m_res  = 0;
  bit          m_dq   = 0;
  bit          m_edge, m_pop, m_canpush;
  int          m_tpop = 0;
  logic [15:0] m_x    = '0;
  logic [17:0] m_rv   = '0;
  bit          m_re   = 0;

  always @(posedge clk) begin
    m_edge = exp_done && !m_dq;
    if (rst) begin
      mq.delete();
      m_job = 0; m_res = 0; m_dq = 0;
    end else begin
      m_pop     = !m_job && !m_res && mq.size() > 0;
      m_canpush = mq.size() < DEPTH;
      m_dq      = exp_done;
      if (m_res && out_ready) m_res = 0;
      if (m_job && m_cyc >= m_tpop + START_LEN + 1) begin
        if (m_edge) begin
          m_res = 1; m_rv = acc_f(m_x); m_re = 0; m_job = 0;
        end else if (m_cyc == m_tpop + START_LEN + TIMEOUT) begin
          m_res = 1; m_rv = '0; m_re = 1; m_job = 0;
        end
      end
      if (m_pop) begin
        m_x = mq.pop_front(); m_tpop = m_cyc; m_job = 1;
      end
      if (in_valid && m_canpush) mq.push_back(in_x);
    end
    m_cyc++;
    m_live = 1;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      check("exp_start", 32'(exp_start),
            32'(m_job && m_cyc >= m_tpop + 1 && m_cyc <= m_tpop + START_LEN));
      check("busy", 32'(busy), 32'(m_job || m_res || mq.size() > 0));
      check("out_valid", 32'(out_valid), 32'(m_res));
      if (m_job) check("exp_x", 32'(exp_x), 32'(m_x));
      if (m_res) begin
        check("out_result", 32'(out_result), 32'(m_rv));
        check("out_err", 32'(out_err), 32'(m_re));
      end
    end
  end

  // Event monitor for the directed scenarios
  int          mc = 0;
  bit          ps = 0;
  bit          pov = 0;
  int          st_rise = 0, st_fall = 0, st_len = 0, run = 0;
  int          n_starts = 0, n_falls = 0, ov_rise = 0;
  logic [17:0] res_q[$];
  logic        err_q[$];
  int          hs_q[$];

  always @(negedge clk) begin
    mc++;
    if (exp_start === 1'b1 && !ps) begin st_rise = mc; n_starts++; end
    if (exp_start === 1'b1) run++;
    if (exp_start === 1'b0 && ps) begin
      st_fall = mc; st_len = run; run = 0; n_falls++;
    end
    if (out_valid === 1'b1 && !pov) ov_rise = mc;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      res_q.push_back(out_result);
      err_q.push_back(out_err);
      hs_q.push_back(mc);
    end
    ps  = (exp_start === 1'b1);
    pov = (out_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x);
    in_valid = 1'b1;
    in_x     = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, input string tag);
    int i = 0;
    while (res_q.size() < n && i < budget) begin
      @(negedge clk); #1; i++;
    end
    if (res_q.size() < n) begin
      n_total++;
      $display("FAIL %s: got %0d results want %0d", tag, res_q.size(), n);
    end
  endtask

  task automatic wait_fall(input int budget, input string tag);
    int f0 = n_falls;
    int i  = 0;
    while (n_falls == f0 && i < budget) begin
      @(negedge clk); #1; i++;
    end
    if (n_falls == f0) begin
      n_total++;
      $display("FAIL %s: no exp_start fall within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int i = 0;
    while (out_valid !== 1'b1 && i < budget) begin
      @(negedge clk); #1; i++;
    end
    if (out_valid !== 1'b1) begin
      n_total++;
      $display("FAIL %s: out_valid not seen within %0d cycles", tag, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_exp_start"}, 32'(exp_start), 32'd0);
    check({tag, "_exp_x"}, 32'(exp_x), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_result"}, 32'(out_result), 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [15:0] burst_x [4] = '{16'd3080, 16'd2481, 16'd0, 16'd65535};
  logic [17:0] burst_r [4] = '{18'h10C58, 18'h0F64E, 18'h0FFFF, 18'h30000};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk); #1;
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // Single job
    push(16'd3080);
    wait_results(1, 200, "single_wait");
    if (res_q.size() >= 1) begin
      check("single_result", 32'(res_q[0]), 32'h10C58);
      check("single_err", 32'(err_q[0]), 32'd0);
    end
    check("single_start_len", st_len, START_LEN);
    check("single_latency", ov_rise - st_rise, 21);

    // Backpressure
    tick();
    res_q.delete(); err_q.delete(); hs_q.delete();
    out_ready = 1'b0;
    push(16'd100);
    push(16'd200);
    wait_valid(200, "bp_wait");
    repeat (50) tick();
    @(negedge clk); #1;
    check("bp_valid_held", 32'(out_valid), 32'd1);
    check("bp_result_held", 32'(out_result), 32'h0FF9B);
    check("bp_no_start", n_starts, 2);
    tick();
    out_ready = 1'b1;
    wait_results(2, 200, "bp_results");
    if (res_q.size() >= 2) begin
      check("bp_res0", 32'(res_q[0]), 32'h0FF9B);
      check("bp_res1", 32'(res_q[1]), 32'h0FF37);
      check("bp_restart_gap", st_rise - hs_q[0], 2);
    end
    check("bp_starts", n_starts, 3);

    // Burst behind a long blocker job
    tick();
    res_q.delete(); err_q.delete(); hs_q.delete();
    acc_lat = 30;
    push(16'd3080);
    wait_fall(100, "burst_blocker");
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_x = burst_x[i];
      @(negedge clk); #1;
      check("burst_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_x = 16'd1234;
    @(negedge clk); #1;
    check("burst_full", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    wait_results(5, 600, "burst_results");
    if (res_q.size() >= 5) begin
      check("burst_blocker_res", 32'(res_q[0]), 32'h10C58);
      for (int i = 0; i < 4; i++)
        check("burst_res", 32'(res_q[i+1]), 32'(burst_r[i]));
    end

    // Sticky done across jobs
    tick();
    res_q.delete(); err_q.delete(); hs_q.delete();
    acc_mode = M_STICKY;
    acc_lat  = 20;
    push(16'd3080);
    push(16'd2481);
    wait_results(2, 300, "sticky_results");
    if (res_q.size() >= 2) begin
      check("sticky_res0", 32'(res_q[0]), 32'h10C58);
      check("sticky_res1", 32'(res_q[1]), 32'h0F64E);
    end
    check("sticky_fresh_edge", ov_rise - st_rise, 21);
    check("sticky_starts", n_starts, 10);
    acc_mode = M_PULSE;

    // Timeout
    tick();
    res_q.delete(); err_q.delete(); hs_q.delete();
    acc_mode = M_NEVER;
    tick();
    push(16'd2481);
    wait_results(1, 1200, "timeout_wait");
    if (res_q.size() >= 1) begin
      check("timeout_result", 32'(res_q[0]), 32'd0);
      check("timeout_err", 32'(err_q[0]), 32'd1);
    end
    check("timeout_cycles", ov_rise - st_fall, TIMEOUT);
    tick(); tick();
    @(negedge clk); #1;
    check("timeout_idle", 32'(busy), 32'd0);

    // Reset mid-WAIT with two operands queued
    tick();
    res_q.delete(); err_q.delete(); hs_q.delete();
    acc_mode = M_PULSE;
    acc_lat  = 40;
    push(16'd100);
    wait_fall(100, "rst_job");
    tick();
    push(16'd200);
    push(16'd300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("midrst");
    tick();
    push(16'd3080);
    wait_results(1, 300, "post_rst");
    if (res_q.size() >= 1) begin
      check("post_rst_res", 32'(res_q[0]), 32'h10C58);
      check("post_rst_err", 32'(err_q[0]), 32'd0);
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exp_dispatcher.md
# exp_dispatcher

Front-end sequencer for the exponential accelerator. Queues operands arriving on a valid/ready stream and launches the accelerator one operand at a time with a `start` pulse. It then waits for `done` and returns `{intpart, fracpart}` on a valid/ready output stream. A timeout guard covers an accelerator that never signals completion.

## Interface
Parameters:
- DEPTH, 4: operand FIFO depth; power of two, ≥2.
- START_LEN, 2: number of cycles `exp_start` is held high per launch; ≥1.
- TIMEOUT, 1023: cycles in WAIT without a `done` edge before the job is aborted.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand available.
- in_ready  out  1  operand accepted when in_valid && in_ready.
- in_x  in  16  operand, Q0.16 fraction.
- exp_start  out  1  launch request to accelerator.
- exp_x  out  16  operand to accelerator.
- exp_done  in  1  accelerator completion level.
- exp_intpart  in  2  accelerator integer result.
- exp_fracpart  in  16  accelerator fractional result.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_result  out  18  {intpart, fracpart}.
- out_err  out  1  qualifies out_result; 1 = timeout, result forced to 0.
- busy  out  1  state != IDLE or FIFO non-empty.

## Operation
- FIFO push condition: in_valid && in_ready.
  - in_ready = !full.
  - Push and pop in the same cycle are legal when non-empty; the count is unchanged.
  - There is no bypass: an operand pushed into an empty FIFO is poppable the next cycle.
- FSM states: IDLE, START, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop, load exp_x, clear counter, go to START.
  - START: exp_start = 1 for exactly START_LEN cycles, then go to WAIT.
  - WAIT: on a done rising edge (exp_done && !done_q, done_q registered), capture {exp_intpart, exp_fracpart}, set out_err = 0, out_valid = 1, go to HOLD. If the counter reaches TIMEOUT first, set out_result = 0, out_err = 1, out_valid = 1, go to HOLD.
  - HOLD: on out_ready, out_valid = 0 and go to IDLE.
- Done detection:
  - Rising-edge detection: a done level left high from the previous job does not complete the next job.
  - Edges seen outside WAIT are ignored. done_q still tracks exp_done in every state.
- exp_x is stable from entry to START until leaving WAIT.
- out_result and out_err are stable while out_valid is high.
- The wait counter is 10 bits minimum: width = clog2(TIMEOUT+1). It saturates and does not wrap.

## Timing
- Reset values: in_ready=1, exp_start=0, exp_x=0, out_valid=0, out_result=0, out_err=0, busy=0. FIFO is emptied, FSM in IDLE, done_q=0.
- Reset mid-job:
  - Reset aborts immediately; the queued operands are lost.
  - exp_start drops in the cycle after rst is sampled.
- Launch latency:
  - An operand accepted at cycle 0 into an empty FIFO pops at cycle 1.
  - exp_start is high during cycles 2..1+START_LEN.
- Result latency:
  - A done edge sampled at cycle n gives out_valid=1 at cycle n+1.
  - The earliest next pop is the cycle after the out handshake, so exp_start can rise at the earliest 2 cycles after that handshake.
- Throughput: one job in flight; the FIFO absorbs bursts of up to DEPTH operands.
- Simultaneous events:
  - A done edge in the same cycle the counter hits TIMEOUT: done wins, with out_err=0.
  - Push while in HOLD is allowed.

## Structure
- Shared package exp_pkg holds:
  - X_W=16, INT_W=2, FRAC_W=16, RES_W=INT_W+FRAC_W.
  - The state enum {IDLE, START, WAIT, HOLD}.
  - This package is also imported by the accelerator and its bench.
- One sub-module, exp_fifo: a parameterised synchronous FIFO with full/empty/count.
- The FSM, start-length counter, timeout counter and output register live in exp_dispatcher.

## Test plan
- Single job: push x=3080; the accelerator model asserts done for 1 cycle, 20 cycles after the start rises, returning int=1, frac=3160. Required: out_result=18'h10C58, out_err=0, exp_start high for exactly 2 cycles.
- Burst: push 3080, 2481, 0, 65535 back-to-back with out_ready=1. Required: in_ready stays 1 for 4 pushes and drops on a 5th push attempted before the first pop; results come out in order; each exp_x is stable during its job.
- Backpressure: hold out_ready=0 for 50 cycles after the first result. Required: out_valid and out_result are held; no new exp_start occurs until the handshake.
- Sticky done: the model holds done high across jobs. Required: the second job completes only on a fresh rising edge and is not completed by the stale level.
- Timeout: the model never asserts done. Required: out_valid rises exactly TIMEOUT cycles after entry to WAIT, with out_result=0 and out_err=1; the FSM then returns to IDLE.
- Reset mid-WAIT with 2 operands queued. Required: the next cycle shows all outputs at reset values and busy=0; a following push operates normally.
